// File: rtl/rvsteel_bus_pkg.sv
// Shared definitions for the RISC-V Steel two-manager bus arbiter.
//   - Arbiter state encoding (IDLE / BUSY)
//   - IO bus widths: address, data, write strobe
//   - Manager index constants used for the owner and priority registers
package rvsteel_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic MGR_M0 = 1'b0;
  localparam logic MGR_M1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/rvsteel_bus_watchdog.sv
// Response-timeout counter for the bus arbiter.
// Ports:
//   clock, reset  - system clock, asynchronous active-low reset
//   start_i       - a transaction is granted this cycle; counter clears
//   active_i      - a granted transaction is waiting for its response
//   response_i    - the subordinate answered this cycle
//   expired_o     - combinational pulse: counter reached TIMEOUT_CYCLES with
//                   no response this cycle (never asserted when TIMEOUT_CYCLES=0)
module rvsteel_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic start_i,
  input  logic active_i,
  input  logic response_i,
  output logic expired_o
);

  localparam bit ENABLED = (TIMEOUT_CYCLES > 0);
  // A zero limit still needs a 1-bit counter to keep the vector legal.
  localparam int CNT_W = ENABLED ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  // A response in the limit cycle wins: the transaction completes normally.
  assign expired_o = ENABLED && active_i && !response_i && (count_q == LIMIT);

  always_comb begin
    // NOTE: default first so every path assigns count_d; no latch is inferred.
    count_d = count_q;
    if (start_i) begin
      count_d = '0;
    end else if (ENABLED && active_i && !response_i && (count_q != LIMIT)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignment for state so all flops update together.
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rvsteel_bus_arbiter.sv
// Two-manager, one-subordinate arbiter for the RISC-V Steel IO bus.
// Round-robin, locked per transaction, zero added latency on grant and on
// response, with a watchdog that terminates unanswered transactions.
// Ports:
//   clock, reset       - system clock, asynchronous active-low reset
//   m0_* / m1_*        - manager side: address, write data, strobe, read/write
//                        request in; read data and read/write response out
//   s_*                - subordinate side: forwarded address, data, strobe,
//                        requests out; read data and responses in
//   timeout_error      - one-cycle pulse when the watchdog ends a transaction
module rvsteel_bus_arbiter
  import rvsteel_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clock,
  input  logic              reset,
  // manager 0
  input  logic [ADDR_W-1:0] m0_rw_address,
  input  logic [DATA_W-1:0] m0_write_data,
  input  logic [STRB_W-1:0] m0_write_strobe,
  input  logic              m0_read_request,
  input  logic              m0_write_request,
  output logic [DATA_W-1:0] m0_read_data,
  output logic              m0_read_response,
  output logic              m0_write_response,
  // manager 1
  input  logic [ADDR_W-1:0] m1_rw_address,
  input  logic [DATA_W-1:0] m1_write_data,
  input  logic [STRB_W-1:0] m1_write_strobe,
  input  logic              m1_read_request,
  input  logic              m1_write_request,
  output logic [DATA_W-1:0] m1_read_data,
  output logic              m1_read_response,
  output logic              m1_write_response,
  // subordinate
  output logic [ADDR_W-1:0] s_rw_address,
  output logic [DATA_W-1:0] s_write_data,
  output logic [STRB_W-1:0] s_write_strobe,
  output logic              s_read_request,
  output logic              s_write_request,
  input  logic [DATA_W-1:0] s_read_data,
  input  logic              s_read_response,
  input  logic              s_write_response,
  // status
  output logic              timeout_error
);

  state_e state_q;
  logic   owner_q;  // manager holding the bus while BUSY
  logic   prio_q;   // manager that wins a tie in IDLE

  logic m0_active, m1_active, any_active;
  logic winner, sel, fwd_en, busy, expired, sub_resp;
  logic rsp_rd, rsp_wr;
  logic [DATA_W-1:0] rsp_data;

  assign m0_active  = m0_read_request | m0_write_request;
  assign m1_active  = m1_read_request | m1_write_request;
  assign any_active = m0_active | m1_active;

  // The priority pointer only matters on contention; a lone requester wins.
  always_comb begin
    winner = MGR_M0;
    if (m0_active && m1_active) begin
      winner = prio_q;
    end else if (m1_active) begin
      winner = MGR_M1;
    end
  end

  // Reset gates every output so nothing leaks while reset is low, even though
  // the manager inputs keep driving the combinational paths.
  assign busy   = reset && (state_q == ST_BUSY);
  assign sel    = (state_q == ST_BUSY) ? owner_q : winner;
  assign fwd_en = busy || (reset && any_active);

  always_comb begin
    s_rw_address    = '0;
    s_write_data    = '0;
    s_write_strobe  = '0;
    s_read_request  = 1'b0;
    s_write_request = 1'b0;
    if (fwd_en) begin
      if (sel == MGR_M1) begin
        s_rw_address    = m1_rw_address;
        s_write_data    = m1_write_data;
        s_write_strobe  = m1_write_strobe;
        s_read_request  = m1_read_request;
        s_write_request = m1_write_request;
      end else begin
        s_rw_address    = m0_rw_address;
        s_write_data    = m0_write_data;
        s_write_strobe  = m0_write_strobe;
        s_read_request  = m0_read_request;
        s_write_request = m0_write_request;
      end
    end
  end

  assign sub_resp = s_read_response | s_write_response;

  rvsteel_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .start_i   ((state_q == ST_IDLE) && any_active),
    .active_i  (busy),
    .response_i(sub_resp),
    .expired_o (expired)
  );

  // Responses exist only while BUSY, so late responses in IDLE are dropped.
  // A timeout answers with the owner's own request type(s) and zero data;
  // the forwarded s_*_request already carries the owner's type.
  assign rsp_rd   = busy && (s_read_response  || (expired && s_read_request));
  assign rsp_wr   = busy && (s_write_response || (expired && s_write_request));
  assign rsp_data = (busy && !expired) ? s_read_data : '0;

  assign m0_read_response  = rsp_rd && (owner_q == MGR_M0);
  assign m0_write_response = rsp_wr && (owner_q == MGR_M0);
  assign m0_read_data      = (owner_q == MGR_M0) ? rsp_data : '0;
  assign m1_read_response  = rsp_rd && (owner_q == MGR_M1);
  assign m1_write_response = rsp_wr && (owner_q == MGR_M1);
  assign m1_read_data      = (owner_q == MGR_M1) ? rsp_data : '0;

  assign timeout_error = expired;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= MGR_M0;
      prio_q  <= MGR_M0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_active) begin
            owner_q <= winner;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (sub_resp || expired) begin
            state_q <= ST_IDLE;
            prio_q  <= ~owner_q;  // the other manager wins the next tie
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvsteel_bus_arbiter.sv
// Self-checking bench for rvsteel_bus_arbiter: a scoreboard of expected
// manager responses filled at issue time from a word-level memory model,
// drained by a monitor whenever a manager sees a response.
module tb_rvsteel_bus_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  // main DUT (TIMEOUT_CYCLES = 4)
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m0_strb, m1_strb, s_strb;
  logic        m0_rd, m0_wr, m0_rresp, m0_wresp, m1_rd, m1_wr, m1_rresp, m1_wresp;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_rd, s_wr, s_rresp, s_wresp, tmo_err;

  // second DUT with the watchdog disabled
  logic [31:0] w_m0_addr, w_m0_rdata, w_m1_rdata, w_s_addr, w_s_wdata, w_s_rdata;
  logic [3:0]  w_s_strb;
  logic        w_m0_rd, w_m0_rresp, w_m0_wresp, w_m1_rresp, w_m1_wresp;
  logic        w_s_rd, w_s_wr, w_s_rresp, w_tmo;

  rvsteel_bus_arbiter #(.TIMEOUT_CYCLES(4)) u_dut (
    .clock(clock), .reset(reset),
    .m0_rw_address(m0_addr), .m0_write_data(m0_wdata), .m0_write_strobe(m0_strb),
    .m0_read_request(m0_rd), .m0_write_request(m0_wr), .m0_read_data(m0_rdata),
    .m0_read_response(m0_rresp), .m0_write_response(m0_wresp),
    .m1_rw_address(m1_addr), .m1_write_data(m1_wdata), .m1_write_strobe(m1_strb),
    .m1_read_request(m1_rd), .m1_write_request(m1_wr), .m1_read_data(m1_rdata),
    .m1_read_response(m1_rresp), .m1_write_response(m1_wresp),
    .s_rw_address(s_addr), .s_write_data(s_wdata), .s_write_strobe(s_strb),
    .s_read_request(s_rd), .s_write_request(s_wr), .s_read_data(s_rdata),
    .s_read_response(s_rresp), .s_write_response(s_wresp),
    .timeout_error(tmo_err)
  );

  rvsteel_bus_arbiter #(.TIMEOUT_CYCLES(0)) u_dut_nowd (
    .clock(clock), .reset(reset),
    .m0_rw_address(w_m0_addr), .m0_write_data(32'h0), .m0_write_strobe(4'h0),
    .m0_read_request(w_m0_rd), .m0_write_request(1'b0), .m0_read_data(w_m0_rdata),
    .m0_read_response(w_m0_rresp), .m0_write_response(w_m0_wresp),
    .m1_rw_address(32'h0), .m1_write_data(32'h0), .m1_write_strobe(4'h0),
    .m1_read_request(1'b0), .m1_write_request(1'b0), .m1_read_data(w_m1_rdata),
    .m1_read_response(w_m1_rresp), .m1_write_response(w_m1_wresp),
    .s_rw_address(w_s_addr), .s_write_data(w_s_wdata), .s_write_strobe(w_s_strb),
    .s_read_request(w_s_rd), .s_write_request(w_s_wr), .s_read_data(w_s_rdata),
    .s_read_response(w_s_rresp), .s_write_response(1'b0),
    .timeout_error(w_tmo)
  );

  // ---------------------------------------------------------------- checking
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] data;
    bit          to;
    int          lat;  // -1: not checked
    int          t0;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   exp_grant[$];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Memories: word index = address[9:2]. m0 uses 0x100.., m1 uses 0x200..,
  // so each manager's reads depend only on its own earlier writes.
  logic [31:0] model_mem [256];
  logic [31:0] sub_mem   [256];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic set_mgr(input int m, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] st);
    if (m == 0) begin
      m0_rd = rd; m0_wr = wr; m0_addr = a; m0_wdata = d; m0_strb = st;
    end else begin
      m1_rd = rd; m1_wr = wr; m1_addr = a; m1_wdata = d; m1_strb = st;
    end
  endtask

  // Issue one transaction and hold it until the manager sees a response.
  // Called and returns at posedge+1.
  task automatic do_txn(input int m, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] st, input bit to, input int lat);
    exp_t e;
    bit got;
    logic [7:0] w;
    w = a[9:2];
    e.rd = rd; e.wr = wr; e.to = to; e.lat = lat; e.t0 = cyc;
    e.data = (rd && !to) ? model_mem[w] : 32'h0;
    if (wr && !to) model_mem[w] = merge(model_mem[w], d, st);
    if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    set_mgr(m, rd, wr, a, d, st);
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (m == 0 ? (m0_rresp | m0_wresp) : (m1_rresp | m1_wresp)) begin
        got = 1;
        break;
      end
    end
    check($sformatf("m%0d_handshake", m), got, 1);
    @(posedge clock); #1;
    set_mgr(m, 0, 0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rand_mgr(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      bit rd;
      a  = 32'h100 * (m + 1) + (32'($urandom_range(0, 15)) << 2);
      rd = 1'($urandom_range(0, 1));
      do_txn(m, rd, !rd, a, $urandom, rd ? 4'h0 : 4'($urandom_range(1, 15)), 0, -1);
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    end
  endtask

  // ------------------------------------------------------- subordinate model
  int sub_delay = 1;
  bit sub_rand  = 0;
  bit sub_mute  = 0;
  bit stray_req = 0;

  initial begin : sub_model
    int          cd;
    bit          pend, p_rd;
    logic [7:0]  p_w;
    logic [31:0] p_data;
    logic [3:0]  p_strb;
    int          g;
    s_rdata = '0; s_rresp = 0; s_wresp = 0; pend = 0; cd = 0;
    forever begin
      @(posedge clock); #1;
      s_rresp = 0; s_wresp = 0; s_rdata = '0;
      if (!reset) begin
        pend = 0;
      end else if (pend) begin
        cd--;
        if (cd == 0) begin
          pend = 0;
          if (p_rd) begin
            s_rresp = 1; s_rdata = sub_mem[p_w];
          end else begin
            s_wresp = 1; sub_mem[p_w] = merge(sub_mem[p_w], p_data, p_strb);
          end
        end
      end else if (stray_req) begin
        stray_req = 0; s_rresp = 1; s_rdata = 32'h5A5A_5A5A;
      end
      @(negedge clock);
      if (reset && !sub_mute && !pend && !(s_rresp | s_wresp) && (s_rd | s_wr)) begin
        p_rd = s_rd; p_w = s_addr[9:2]; p_data = s_wdata; p_strb = s_strb;
        cd = sub_rand ? $urandom_range(1, 5) : sub_delay;
        pend = 1;
        if (exp_grant.size() > 0) begin
          g = exp_grant.pop_front();
          check("grant_order", s_addr[9], g[0]);
        end
      end
    end
  end

  // ----------------------------------------------------------------- monitor
  task automatic mon_one(input int m, input logic rr, input logic wr_,
                         input logic [31:0] rdata, input logic [31:0] other);
    exp_t e;
    if (!(rr | wr_)) return;
    if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
      check($sformatf("m%0d_unexpected_resp", m), {rr, wr_}, 2'b00);
      return;
    end
    if (m == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
    check($sformatf("m%0d_resp_type", m), {rr, wr_}, {e.rd, e.wr});
    if (e.rd) check($sformatf("m%0d_read_data", m), rdata, e.data);
    check($sformatf("m%0d_timeout_error", m), tmo_err, e.to);
    check($sformatf("m%0d_other_rdata", m), other, 32'h0);
    if (e.lat >= 0) check($sformatf("m%0d_latency", m), cyc - e.t0, e.lat);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_one(0, m0_rresp, m0_wresp, m0_rdata, m1_rdata);
        mon_one(1, m1_rresp, m1_wresp, m1_rdata, m0_rdata);
        if (!(m0_rresp | m0_wresp | m1_rresp | m1_wresp)) check("spurious_timeout", tmo_err, 0);
      end
    end
  end

  initial begin : global_bound
    #2_000_000;
    $display("FAIL global_timeout: got=no finish want=finish");
    $fatal(1, "bench timed out");
  end

  // -------------------------------------------------------------- main flow
  task automatic check_all_zero(input string tag);
    check({tag, "_s_bus"}, {s_addr, s_wdata}, 64'h0);
    check({tag, "_ctl"}, {s_rd, s_wr, s_strb, m0_rresp, m0_wresp, m1_rresp, m1_wresp, tmo_err}, 0);
    check({tag, "_rdata"}, {m0_rdata, m1_rdata}, 64'h0);
  endtask

  initial begin : main
    bit flag;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 32'hC0DE_0000 | 32'(i);
      sub_mem[i]   = 32'hC0DE_0000 | 32'(i);
    end
    model_mem[64] = 32'hDEAD_BEEF;
    sub_mem[64]   = 32'hDEAD_BEEF;
    reset = 0;
    set_mgr(0, 1, 0, 32'h100, 32'h0, 4'h0);  // requests during reset must not leak
    set_mgr(1, 0, 1, 32'h200, 32'h1234_5678, 4'hF);
    w_m0_rd = 1; w_m0_addr = 32'h104; w_s_rresp = 0; w_s_rdata = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    check("nowd_reset", {w_s_rd, w_s_addr}, 33'h0);
    set_mgr(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_mgr(1, 0, 0, 32'h0, 32'h0, 4'h0);
    w_m0_rd = 0;
    @(posedge clock); #1; reset = 1;
    @(posedge clock); #1;

    // simultaneous back-to-back writes: m0 first, then strict alternation
    exp_grant = '{0, 1, 0, 1, 0, 1};
    fork
      for (int i = 0; i < 3; i++) do_txn(0, 0, 1, 32'h110 + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 0, -1);
      for (int i = 0; i < 3; i++) do_txn(1, 0, 1, 32'h220 + 32'(i * 4), 32'h2000_0000 + 32'(i), 4'hF, 0, -1);
    join
    check("grant_log_drained", exp_grant.size(), 0);

    // single read, forwarded in the request cycle, answered one cycle later
    fork
      do_txn(0, 1, 0, 32'h100, 32'h0, 4'h0, 0, 1);
      begin
        #1;
        check("same_cycle_s_read", {s_rd, s_wr, s_addr}, {1'b1, 1'b0, 32'h100});
        check("m1_quiet", {m1_rresp, m1_wresp, m1_rdata}, 34'h0);
      end
    join

    // randomized concurrent traffic, subordinate latency 1..5
    sub_rand = 1;
    fork
      rand_mgr(0, 40);
      rand_mgr(1, 40);
    join
    sub_rand = 0;
    sub_delay = 1;

    // watchdog expiry on a read and on a write, then a stray late response
    sub_mute = 1;
    do_txn(1, 1, 0, 32'h204, 32'h0, 4'h0, 1, 5);
    do_txn(1, 0, 1, 32'h208, 32'hFFFF_FFFF, 4'hF, 1, 5);
    #1; stray_req = 1;
    @(posedge clock); #3;
    check("stray_not_routed", {m0_rresp, m1_rresp, m0_wresp, m1_wresp, tmo_err}, 0);
    check("stray_rdata", {m0_rdata, m1_rdata}, 64'h0);
    @(posedge clock); #1;
    sub_mute = 0;

    // response in the very cycle the counter reaches the limit
    sub_delay = 5;
    do_txn(0, 1, 0, 32'h100, 32'h0, 4'h0, 0, 5);
    sub_delay = 1;

    // reset while m1 owns the bus; after release m0 wins the tie
    sub_mute = 1;
    set_mgr(1, 1, 0, 32'h20C, 32'h0, 4'h0);
    repeat (2) begin @(posedge clock); #1; end
    set_mgr(0, 0, 1, 32'h114, 32'hAAAA_5555, 4'hF);
    #1; reset = 0;
    #1; check_all_zero("mid_reset");
    set_mgr(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_mgr(1, 0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clock); #1; reset = 1; sub_mute = 0;
    @(posedge clock); #1;
    exp_grant = '{0, 1};
    fork
      do_txn(0, 0, 1, 32'h114, 32'hAAAA_5555, 4'hF, 0, -1);
      do_txn(1, 1, 0, 32'h20C, 32'h0, 4'h0, 0, -1);
    join
    check("post_reset_grants", exp_grant.size(), 0);

    // watchdog disabled: a 300-cycle wait is not cut short
    w_m0_rd = 1; w_m0_addr = 32'h104;
    flag = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      flag |= w_m0_rresp | w_m0_wresp | w_tmo;
    end
    check("nowd_no_timeout", flag, 0);
    check("nowd_forward", {w_s_rd, w_s_addr}, {1'b1, 32'h104});
    @(posedge clock); #1; w_s_rresp = 1; w_s_rdata = 32'h1357_2468;
    #1;
    check("nowd_response", {w_m0_rresp, w_m0_rdata}, {1'b1, 32'h1357_2468});
    check("nowd_no_error", {w_tmo, w_m1_rresp, w_m1_wresp}, 0);
    @(posedge clock); #1; w_s_rresp = 0; w_s_rdata = '0; w_m0_rd = 0;

    repeat (3) @(posedge clock);
    check("scoreboard_empty", exp_q0.size() + exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
